pipo_load_arbiter: RTL
======================

PIPO_LOAD_ARBITER -- requirements
Module: pipo_load_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: req  input  4  load request, bit i = requester i.
REQ-004 SHALL have port: lock  input  4  ownership-hold request, bit i = requester i.
REQ-005 SHALL have port: d_bus  input  16  requester data; requester i owns bits [4i+3:4i].
REQ-006 SHALL have port: gnt  output  4  one-hot grant, registered.
REQ-007 SHALL have port: load  output  1  load strobe to the shared 4-bit PIPO register, registered.
REQ-008 SHALL have port: d  output  4  data to the shared PIPO register, registered.
REQ-009 SHALL have port: owner  output  2  index of the current or last granted requester.
REQ-010 SHALL have port: busy  output  1  high while in GRANT state.
REQ-011 SHALL have port: load_cnt  output  8  count of load cycles issued, wraps 255->0.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and GRANT.
REQ-013 IDLE: if req != 0 at a rising edge, SHALL select the winner, then go to GRANT; otherwise SHALL stay in IDLE with gnt=0 and load=0.
REQ-014 Winner selection SHALL be round-robin: search order starts at index ptr (2-bit) and ascends modulo 4; the first set req bit wins.
REQ-015 On the selecting edge, SHALL register gnt=one-hot(winner), load=1, d=d_bus slice of winner, owner=winner, busy=1 (latency: request sampled at edge N, outputs valid after edge N, PIPO captures at edge N+1).
REQ-016 Each grant without lock SHALL last exactly one cycle; ptr SHALL become owner+1 mod 4 when the grant ends.
REQ-017 At the end of a grant, if req != 0, SHALL issue the next grant on that same edge with no idle bubble, using the updated ptr; otherwise SHALL go to IDLE with gnt=0, load=0.
REQ-018 A requester SHALL be re-granted only after every other active requester has been served once (no starvation).
REQ-019 load_cnt SHALL increment on every edge where the registered load becomes or stays 1, and SHALL wrap 255 -> 0.
REQ-020 d and owner SHALL hold their last values while in IDLE; gnt and load SHALL be 0 in IDLE.
REQ-021 req bits that deassert while not granted SHALL be ignored, with no queuing of past requests.

Reset
REQ-022 reset=1 SHALL immediately force state=IDLE, gnt=0, load=0, d=0, owner=0, busy=0, load_cnt=0, ptr=0, regardless of clk.
REQ-023 reset asserted mid-grant SHALL abort the grant asynchronously; after release, arbitration SHALL restart from ptr=0 on the first rising edge with reset=0.

Configuration
REQ-024 Macro PIPO_ARB_LOCK_EN: when defined, if lock[owner]=1 at the end of a grant cycle, SHALL stay in GRANT with the same owner, load=1, and d re-sampled from the owner's slice each cycle; ptr SHALL stay unchanged until lock[owner] falls.
REQ-025 Without PIPO_ARB_LOCK_EN, the lock port SHALL exist but be ignored, and every grant SHALL last one cycle.

Verification
REQ-026 Reset, then req=4'b0100, d_bus slice2=4'hA -> next cycle gnt=4'b0100, load=1, d=4'hA, owner=2; the following cycle load=0, gnt=0, load_cnt=1.
REQ-027 req=4'b1111 held for 8 cycles from ptr=0 -> gnt sequence 0001,0010,0100,1000,0001,... with no bubble; load_cnt=8.
REQ-028 req=4'b1001 held with ptr=1 -> grants go to 3 then 0 then 3; neither requester is granted twice in a row.
REQ-029 With PIPO_ARB_LOCK_EN: requester 1 granted, lock[1]=1 for 3 cycles while req=4'b1111 and slice1 changes 1->2->3 -> gnt=0010 for 4 cycles, d follows the slice, then gnt=0100.
REQ-030 Assert reset for 1 ns mid-grant of owner 3 -> gnt=0, load=0, load_cnt=0 immediately; next grant with req=4'b1000 -> owner=3, with arbitration restarted from ptr=0.
REQ-031 Without PIPO_ARB_LOCK_EN, repeat REQ-029 -> lock is ignored and grant passes to requester 2 after one cycle.

Source files
------------

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter feeding a shared 4-bit PIPO register.
// Define PIPO_ARB_LOCK_EN to let the owner hold its grant via lock[owner].
module pipo_load_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  lock,
  input  logic [15:0] d_bus,
  output logic [3:0]  gnt,
  output logic        load,
  output logic [3:0]  d,
  output logic [1:0]  owner,
  output logic        busy,
  output logic [7:0]  load_cnt
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;

  logic [3:0]  r_gnt;
  logic        r_load;
  logic [3:0]  r_d;
  logic [1:0]  r_owner;
  logic [1:0]  r_ptr;
  logic [7:0]  r_cnt;

  logic [3:0]  w_gnt_nx;
  logic        w_load_nx;
  logic [3:0]  w_d_nx;
  logic [1:0]  w_owner_nx;
  logic [1:0]  w_ptr_nx;
  logic [7:0]  w_cnt_nx;

  logic [1:0]  w_base;
  logic [1:0]  w_win;
  logic        w_found;
  logic        w_hold;

`ifdef PIPO_ARB_LOCK_EN
  assign w_hold = (r_state == S_GRANT) && lock[r_owner];
`else
  logic w_unused_lock;
  assign w_unused_lock = ^lock;
  assign w_hold        = 1'b0;
`endif

  // A finishing grant searches from owner+1; from IDLE use the saved ptr
  assign w_base = (r_state == S_GRANT) ? (r_owner + 2'd1) : r_ptr;

  always_comb begin
    logic [1:0] v_idx;
    v_idx   = w_base;
    w_found = 1'b0;
    w_win   = w_base;
    for (int k = 3; k >= 0; k--) begin
      v_idx = w_base + 2'(k);
      if (req[v_idx]) begin
        w_found = 1'b1;
        w_win   = v_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:  w_state_nx = w_found ? S_GRANT : S_IDLE;
      S_GRANT: w_state_nx = (w_hold || w_found) ? S_GRANT : S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nx   = 4'd0;
    w_load_nx  = 1'b0;
    w_d_nx     = r_d;
    w_owner_nx = r_owner;
    w_ptr_nx   = r_ptr;
    if (w_hold) begin
      w_gnt_nx  = r_gnt;
      w_load_nx = 1'b1;
      w_d_nx    = d_bus[{r_owner, 2'b00} +: 4];
    end else begin
      if (r_state == S_GRANT) w_ptr_nx = w_base;
      if (w_found) begin
        w_gnt_nx   = 4'd1 << w_win;
        w_load_nx  = 1'b1;
        w_d_nx     = d_bus[{w_win, 2'b00} +: 4];
        w_owner_nx = w_win;
      end
    end
    w_cnt_nx = w_load_nx ? (r_cnt + 8'd1) : r_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt   <= 4'd0;
      r_load  <= 1'b0;
      r_d     <= 4'd0;
      r_owner <= 2'd0;
      r_ptr   <= 2'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_gnt   <= w_gnt_nx;
      r_load  <= w_load_nx;
      r_d     <= w_d_nx;
      r_owner <= w_owner_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  assign gnt      = r_gnt;
  assign load     = r_load;
  assign d        = r_d;
  assign owner    = r_owner;
  assign busy     = (r_state == S_GRANT);
  assign load_cnt = r_cnt;

endmodule
